// File: rtl/nand_tree_pipe.sv
// Pipelined N-input NAND/AND/OR/NOR reduction: a balanced tree of nand-pair AND
// nodes, one register level per tree level, moved by a global valid/ready advance.
module nand_tree_pipe #(
  parameter int N_IN = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] i,
  input  logic [1:0]      mode,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            y,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int LEVELS = (N_IN < 2) ? 1 : $clog2(N_IN);
  localparam int W      = 1 << LEVELS;

  // All stage data registers packed into one vector: stage k holds W>>k bits
  // starting at bit W - 2*(W>>k), so the final single bit sits at W-2.
  logic [W-1:0]    leaf;
  logic [W-2:0]    tree_reg;
  logic [W-2:0]    tree_next;
  logic [LEVELS:1] v_reg;
  logic [LEVELS:1] v_next;
  logic [LEVELS:1] inv_reg;
  logic [LEVELS:1] inv_next;
  logic            adv;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_reg[LEVELS];
  assign y         = tree_reg[W-2] ^ inv_reg[LEVELS];

  // OR/NOR invert the operands (De Morgan); padding uses 1, the AND identity.
  genvar gi;
  genvar gj;
  for (gi = 0; gi < W; gi++) begin : g_leaf
    if (gi < N_IN) begin : g_in
      assign leaf[gi] = i[gi] ^ mode[1];
    end else begin : g_pad
      assign leaf[gi] = 1'b1;
    end
  end

  for (gi = 1; gi <= LEVELS; gi++) begin : g_level
    localparam int WK  = W >> gi;
    localparam int OFS = W - 2 * WK;
    logic [2*WK-1:0] src;

    if (gi == 1) begin : g_first
      assign src = leaf;
    end else begin : g_inner
      assign src = tree_reg[W - 4 * WK +: 2 * WK];
    end

    for (gj = 0; gj < WK; gj++) begin : g_node
      logic nand_ab;
      assign nand_ab           = ~(src[2*gj] & src[2*gj+1]);
      assign tree_next[OFS+gj] = ~(nand_ab & nand_ab);
    end
  end

  // Tree output is AND of conditioned leaves; NAND and OR need it inverted.
  always_comb begin
    v_next      = '0;
    inv_next    = '0;
    v_next[1]   = in_valid;
    inv_next[1] = ~mode[0];
    for (int k = 2; k <= LEVELS; k++) begin
      v_next[k]   = v_reg[k-1];
      inv_next[k] = inv_reg[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tree_reg <= '0;
      v_reg    <= '0;
      inv_reg  <= '0;
    end else if (adv) begin
      tree_reg <= tree_next;
      v_reg    <= v_next;
      inv_reg  <= inv_next;
    end
  end

endmodule

// File: tb/tb_nand_tree_pipe.sv
// Directed bench for nand_tree_pipe at N_IN = 8, 5 and 2 with hand-computed results.
module tb_nand_tree_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] i8;
  logic [1:0] m8;
  logic       iv8, ir8, y8, ov8, or8;
  logic [4:0] i5;
  logic [1:0] m5;
  logic       iv5, ir5, y5, ov5, or5;
  logic [1:0] i2;
  logic [1:0] m2;
  logic       iv2, ir2, y2, ov2, or2;

  nand_tree_pipe #(.N_IN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i(i8), .mode(m8), .in_valid(iv8), .in_ready(ir8),
    .y(y8), .out_valid(ov8), .out_ready(or8));
  nand_tree_pipe #(.N_IN(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .i(i5), .mode(m5), .in_valid(iv5), .in_ready(ir5),
    .y(y5), .out_valid(ov5), .out_ready(or5));
  nand_tree_pipe #(.N_IN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .i(i2), .mode(m2), .in_valid(iv2), .in_ready(ir2),
    .y(y2), .out_valid(ov2), .out_ready(or2));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_seq;
  logic [1:0] v2;

  initial begin
    i8 = '0; m8 = '0; iv8 = 1'b0; or8 = 1'b1;
    i5 = '0; m5 = '0; iv5 = 1'b0; or5 = 1'b1;
    i2 = '0; m2 = '0; iv2 = 1'b0; or2 = 1'b1;

    // Reset state
    #12;
    check("rst_ov8", ov8, 0);
    check("rst_y8", y8, 0);
    check("rst_ir8", ir8, 1);
    check("rst_ov5", ov5, 0);
    check("rst_ov2", ov2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // N=8 NAND 0xFF then 0xFE, latency 3
    i8 = 8'hFF; m8 = 2'b00; iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    check("lat_c1_ov", ov8, 0);
    step();
    check("lat_c2_ov", ov8, 0);
    step();
    check("nand_ff_ov", ov8, 1);
    check("nand_ff_y", y8, 0);
    step();
    check("drain_ov", ov8, 0);
    i8 = 8'hFE; m8 = 2'b00; iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    step();
    step();
    check("nand_fe_ov", ov8, 1);
    check("nand_fe_y", y8, 1);
    step();

    // N=8 streaming all four modes with i=0
    exp_seq = 4'b1001;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        i8 = 8'h00; m8 = c[1:0]; iv8 = 1'b1;
      end else iv8 = 1'b0;
      step();
      if (c >= 2 && c <= 5) begin
        check($sformatf("stream%0d_ov", c - 2), ov8, 1);
        check($sformatf("stream%0d_y", c - 2), y8, exp_seq[3-(c-2)]);
      end
    end
    check("stream_end_ov", ov8, 0);

    // N=8 stall: A=AND FF (1), B=OR 00 (0), C=NOR 00 (1), D=AND FE (0)
    or8 = 1'b0;
    i8 = 8'hFF; m8 = 2'b01; iv8 = 1'b1; step();
    i8 = 8'h00; m8 = 2'b10; step();
    i8 = 8'h00; m8 = 2'b11; step();
    check("stall_a_ov", ov8, 1);
    check("stall_a_y", y8, 1);
    check("stall_ir", ir8, 0);
    i8 = 8'hFE; m8 = 2'b01;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("stall_hold%0d_y", c), y8, 1);
      check($sformatf("stall_hold%0d_ir", c), ir8, 0);
    end
    or8 = 1'b1;
    #1;
    check("unstall_ir", ir8, 1);
    step();
    iv8 = 1'b0;
    check("drain_b_y", y8, 0);
    step();
    check("drain_c_y", y8, 1);
    step();
    check("drain_d_ov", ov8, 1);
    check("drain_d_y", y8, 0);
    step();
    check("drain_done_ov", ov8, 0);

    // N=5: AND 1F=1, NOR 10=0, OR 10=1, NAND 1F=0
    exp_seq = 4'b1010;
    for (int c = 0; c < 7; c++) begin
      iv5 = 1'b1;
      case (c)
        0: begin i5 = 5'h1F; m5 = 2'b01; end
        1: begin i5 = 5'h10; m5 = 2'b11; end
        2: begin i5 = 5'h10; m5 = 2'b10; end
        3: begin i5 = 5'h1F; m5 = 2'b00; end
        default: iv5 = 1'b0;
      endcase
      step();
      if (c >= 2 && c <= 5) begin
        check($sformatf("n5_%0d_ov", c - 2), ov5, 1);
        check($sformatf("n5_%0d_y", c - 2), y5, exp_seq[3-(c-2)]);
      end
    end

    // Asynchronous reset mid-stream with beats in flight
    i8 = 8'hFF; m8 = 2'b01; iv8 = 1'b1;
    step(); step();
    iv8 = 1'b0;
    step();
    check("pre_rst_ov", ov8, 1);
    check("pre_rst_y", y8, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ov", ov8, 0);
    check("async_rst_y", y8, 0);
    check("async_rst_ir", ir8, 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("no_stale%0d_ov", c), ov8, 0);
    end
    i8 = 8'h00; m8 = 2'b00; iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    step();
    check("post_rst_c2_ov", ov8, 0);
    step();
    check("post_rst_ov", ov8, 1);
    check("post_rst_y", y8, 1);
    step();

    // N=2 NAND truth table, 1-cycle latency
    exp_seq = 4'b1110;
    for (int c = 0; c < 5; c++) begin
      if (c < 4) begin
        v2 = c[1:0];
        i2 = v2; m2 = 2'b00; iv2 = 1'b1;
      end else iv2 = 1'b0;
      step();
      if (c < 4) begin
        check($sformatf("n2_%0d_ov", c), ov2, 1);
        check($sformatf("n2_%0d_y", c), y2, exp_seq[3-c]);
      end else check("n2_end_ov", ov2, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
